// File: rtl/wb_stage_buf.sv
// MEM/WB boundary stage: two-entry skid buffer (main M + skid S) carrying
// write-back data and control, with flush, start gating and a retire counter.
module wb_stage_buf #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int ZERO_GUARD = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] ALU_Result_i,
  input  logic [DATA_W-1:0] memory_data_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] ALU_Result_o,
  output logic [DATA_W-1:0] memory_data_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  retired_o
);

  // Handshake: a transfer happens on a cycle where valid and ready are both
  // high (and start_i is high, flush_i low); valid never depends on ready.

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [ADDR_W-1:0] rd;
    logic              rw;
    logic              mtr;
  } entry_t;

  entry_t           m_q, m_d;
  entry_t           s_q, s_d;
  entry_t           in_entry;
  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc;
  logic             ret;
  logic             zero_blk;

  assign in_entry.alu = ALU_Result_i;
  assign in_entry.mem = memory_data_i;
  assign in_entry.rd  = RDaddr_i;
  assign in_entry.rw  = RegWrite_i;
  assign in_entry.mtr = MemtoReg_i;

  assign acc = start_i & in_valid_i & ready_q & ~flush_i;
  assign ret = start_i & m_valid_q & out_ready_i & ~flush_i;

  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    cnt_d     = cnt_q;
    // Flush acts even while start_i is low; data fields are left as they are.
    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      case ({s_valid_q, m_valid_q})
        2'b00: begin
          if (acc) begin
            m_d       = in_entry;
            m_valid_d = 1'b1;
          end
        end
        2'b01: begin
          if (acc && ret) begin
            m_d = in_entry;
          end else if (acc) begin
            s_d       = in_entry;
            s_valid_d = 1'b1;
          end else if (ret) begin
            m_valid_d = 1'b0;
          end
        end
        2'b11: begin
          if (ret) begin
            m_d       = s_q;
            s_valid_d = 1'b0;
          end
        end
        default: begin
          m_valid_d = m_valid_q;
        end
      endcase
      if (ret && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign ready_d = ~s_valid_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      ready_q   <= 1'b1;
      cnt_q     <= '0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
    end
  end

  assign zero_blk      = (ZERO_GUARD != 0) && (m_q.rd == '0);
  assign in_ready_o    = ready_q;
  assign out_valid_o   = m_valid_q & start_i;
  assign ALU_Result_o  = m_q.alu;
  assign memory_data_o = m_q.mem;
  assign RDaddr_o      = m_q.rd;
  assign RegWrite_o    = m_q.rw & out_valid_o & ~zero_blk;
  assign MemtoReg_o    = m_q.mtr & out_valid_o;
  assign occupancy_o   = {1'b0, m_valid_q} + {1'b0, s_valid_q};
  assign retired_o     = cnt_q;

endmodule
